// File: rtl/reg_x_pkg.sv
// Shared constants for the loop-index register pair (I / IREF).
// Imported by reg_x and its enable-register sub-module.
package reg_x_pkg;

    // Default datapath width of I, IREF and the data buses.
    localparam int unsigned DefaultWidth = 16;

    // Value every register bit takes on reset.
    localparam logic ResetBit = 1'b0;

    // Full-width reset pattern for a register of the given width.
    function automatic logic [63:0] reset_pattern(input int unsigned width);
        logic [63:0] pat;
        pat = '0;
        for (int unsigned b = 0; b < 64; b++) begin
            if (b < width) begin
                pat[b] = ResetBit;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/reg_x_en_reg.sv
// Width-parameterised register with synchronous active-low clear and load enable.
// The clear wins over the load enable.
module en_reg
    import reg_x_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_d;
    logic [Width-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= {Width{ResetBit}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_x.sv
// Loop-index register I and limit register IREF, both loaded from the shared data bus.
// Gated read outputs and an I == IREF flag for loop termination in the control unit.
module reg_x
    import reg_x_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_i,
    input  logic             write_iref,
    input  logic             read_i,
    input  logic             read_iref,
    input  logic [WIDTH-1:0] data_in,
    output logic             iflag,
    output logic [WIDTH-1:0] data_out_i,
    output logic [WIDTH-1:0] data_out_iref
);

    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] iref_q;

    en_reg #(
        .Width (WIDTH)
    ) u_i_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (write_i),
        .d     (data_in),
        .q     (i_q)
    );

    en_reg #(
        .Width (WIDTH)
    ) u_iref_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (write_iref),
        .d     (data_in),
        .q     (iref_q)
    );

    // Compare stored values only; no bypass from data_in, so iflag settles one edge after a write.
    always_comb begin
        iflag         = (i_q == iref_q);
        data_out_i    = '0;
        data_out_iref = '0;
        if (read_i) begin
            data_out_i = i_q;
        end
        if (read_iref) begin
            data_out_iref = iref_q;
        end
    end

endmodule

// File: tb/tb_reg_x.sv
// Self-checking bench for reg_x: directed steps from the test plan, then random traffic
// checked against a two-variable behavioural model, before and after every edge.
module tb_reg_x;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         write_i;
    logic         write_iref;
    logic         read_i;
    logic         read_iref;
    logic [W-1:0] data_in;
    logic         iflag;
    logic [W-1:0] data_out_i;
    logic [W-1:0] data_out_iref;

    int checks;
    int errors;

    // Reference state: what I and IREF must hold, and whether they are known yet.
    logic [W-1:0] m_i;
    logic [W-1:0] m_iref;
    bit           m_valid;

    reg_x #(
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_i       (write_i),
        .write_iref    (write_iref),
        .read_i        (read_i),
        .read_iref     (read_iref),
        .data_in       (data_in),
        .iflag         (iflag),
        .data_out_i    (data_out_i),
        .data_out_iref (data_out_iref)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] e_i;
        logic [W-1:0] e_r;
        e_i = read_i ? m_i : '0;
        e_r = read_iref ? m_iref : '0;
        check({tag, ".out_i"}, data_out_i, e_i);
        check({tag, ".out_iref"}, data_out_iref, e_r);
        check({tag, ".iflag"}, {{(W-1){1'b0}}, iflag}, {{(W-1){1'b0}}, (m_i == m_iref)});
    endtask

    // Drive one cycle's inputs, check old values before the edge, then new values after it.
    task automatic step(input string tag, input logic rn, input logic wi, input logic wr,
                        input logic ri, input logic rr, input logic [W-1:0] din);
        @(negedge clk);
        rst_n      = rn;
        write_i    = wi;
        write_iref = wr;
        read_i     = ri;
        read_iref  = rr;
        data_in    = din;
        #1;
        if (m_valid) check_outputs({tag, ".pre"});
        @(posedge clk);
        if (!rn) begin
            m_i    = '0;
            m_iref = '0;
        end else begin
            if (wi) m_i = din;
            if (wr) m_iref = din;
        end
        m_valid = m_valid || !rn;
        #1;
        if (m_valid) check_outputs({tag, ".post"});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_valid    = 1'b0;
        m_i        = '0;
        m_iref     = '0;
        rst_n      = 1'b0;
        write_i    = 1'b0;
        write_iref = 1'b0;
        read_i     = 1'b0;
        read_iref  = 1'b0;
        data_in    = '0;

        // Reset with writes pending: reset wins.
        step("rst0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF);
        step("rst1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF);
        check("rst.iflag_const", {{(W-1){1'b0}}, iflag}, 16'd1);
        step("rst_rd", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        check("rst.out_i_zero", data_out_i, 16'd0);

        // Load reference, then count up to it and past it.
        step("ref5", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
        step("i0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        check("cnt0.iflag", {{(W-1){1'b0}}, iflag}, 16'd0);
        step("i2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
        step("i3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        step("i4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
        check("cnt4.iflag", {{(W-1){1'b0}}, iflag}, 16'd0);
        step("i5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
        check("cnt5.iflag", {{(W-1){1'b0}}, iflag}, 16'd1);
        step("i6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6);
        check("cnt6.iflag", {{(W-1){1'b0}}, iflag}, 16'd0);

        // Read gating.
        step("rd_both", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
        check("rd.i6", data_out_i, 16'd6);
        check("rd.iref5", data_out_iref, 16'd5);
        step("rd_ref", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        check("rd.i_gated", data_out_i, 16'd0);
        check("rd.iref_kept", data_out_iref, 16'd5);

        // Simultaneous writes.
        step("both", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hABCD);
        check("both.i", data_out_i, 16'hABCD);
        check("both.iref", data_out_iref, 16'hABCD);

        // Reset priority mid-operation.
        step("set_i3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        step("set_r7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
        step("rst_mid", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd9);
        check("rst_mid.i", data_out_i, 16'd0);

        // Read during write: old value before edge, new after.
        step("set_i4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
        step("rdw", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8);
        check("rdw.i8", data_out_i, 16'd8);

        // Random traffic; data often copies a stored value so iflag toggles both ways.
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] d;
            int unsigned sel;
            sel = $urandom_range(0, 7);
            if (sel == 0) d = m_i;
            else if (sel == 1) d = m_iref;
            else if (sel == 2) d = W'($urandom_range(0, 3));
            else d = W'($urandom);
            step("rnd", ($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
